seq_controller: RTL and testbench

SEQ_CONTROLLER -- requirements
Module: seq_controller

---
 rtl/seq_controller.sv | 212 +++++++++++++++++++++
 tb/tb_seq_controller.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_controller.sv
// seq_controller: multi-cycle control FSM for a small RV64I subset
// (add/sub/and/or, addi, ld, sd, beq). It drives the datapath strobes and
// runs the instruction-fetch and data-memory handshakes.
// Optional performance counters are enabled by defining SEQ_CTRL_PERF_COUNTERS_EN.
module seq_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    output logic        imem_req,
    input  logic        imem_ready,
    input  logic [31:0] instr,
    input  logic        dmem_ready,
    input  logic        Zero,
    output logic [3:0]  ALUOp,
    output logic        ALUSrc,
    output logic        Branch,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        MemtoReg,
    output logic        RegWrite,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic        PCSrc,
    output logic [2:0]  state,
    output logic        illegal_instr,
    output logic [31:0] cycle_count,
    output logic [31:0] instret_count
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        DECODE  = 3'd2,
        EXECUTE = 3'd3,
        MEM     = 3'd4,
        WB      = 3'd5,
        HALT    = 3'd6
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic        illegal_q, illegal_d;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7_b5;
    logic        is_r, is_addi, is_ld, is_sd, is_beq, legal, complete;
    logic [3:0]  exe_aluop;
    logic        unused_ir_bits;

    assign opcode    = ir_q[6:0];
    assign funct3    = ir_q[14:12];
    assign funct7_b5 = ir_q[30];
    // Register and immediate fields belong to the datapath, not to control
    assign unused_ir_bits = ^{ir_q[31], ir_q[29:15], ir_q[11:7]};

    // Classify the latched instruction, pick its ALU operation and flag the completion cycle
    always_comb begin
        is_r      = 1'b0;
        exe_aluop = 4'b0000;
        if (opcode == 7'b0110011) begin
            case (funct3)
                3'b000: begin
                    is_r      = 1'b1;
                    exe_aluop = funct7_b5 ? 4'b0110 : 4'b0010;
                end
                3'b111: begin
                    is_r      = !funct7_b5;
                    exe_aluop = 4'b0111;
                end
                3'b110: begin
                    is_r      = !funct7_b5;
                    exe_aluop = 4'b0001;
                end
                default: is_r = 1'b0;
            endcase
        end
        is_addi = (opcode == 7'b0010011) && (funct3 == 3'b000);
        is_ld   = (opcode == 7'b0000011) && (funct3 == 3'b011);
        is_sd   = (opcode == 7'b0100011) && (funct3 == 3'b011);
        is_beq  = (opcode == 7'b1100011) && (funct3 == 3'b000);
        if (is_addi) exe_aluop = 4'b0010;
        if (is_beq)  exe_aluop = 4'b0110;
        legal    = is_r || is_addi || is_ld || is_sd || is_beq;
        complete = ((state_q == EXECUTE) && is_beq) ||
                   ((state_q == MEM) && is_sd && dmem_ready) ||
                   (state_q == WB);
    end

    // Next-state logic, instruction latch and sticky illegal flag
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        illegal_d = illegal_q;
        case (state_q)
            IDLE:    if (start) state_d = FETCH;
            FETCH: begin
                if (imem_ready) begin
                    ir_d    = instr;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (legal) begin
                    state_d = EXECUTE;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = HALT;
                end
            end
            EXECUTE: begin
                if (is_ld || is_sd) state_d = MEM;
                else if (!is_beq)   state_d = WB;
            end
            MEM:     if (dmem_ready && is_ld) state_d = WB;
            WB:      state_d = WB;
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase
        // Every completing instruction shares the same exit: stop is only honoured here
        if (complete) state_d = stop ? IDLE : FETCH;
    end

    // Control outputs decoded from state and latched IR
    always_comb begin
        imem_req = 1'b0;
        IRWrite  = 1'b0;
        ALUOp    = 4'b0000;
        ALUSrc   = 1'b0;
        Branch   = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        MemtoReg = 1'b0;
        RegWrite = 1'b0;
        PCWrite  = 1'b0;
        PCSrc    = 1'b0;
        case (state_q)
            FETCH: begin
                imem_req = 1'b1;
                IRWrite  = imem_ready;
            end
            EXECUTE: begin
                ALUOp  = exe_aluop;
                ALUSrc = is_addi || is_ld || is_sd;
                if (is_beq) begin
                    Branch  = 1'b1;
                    PCWrite = 1'b1;
                    PCSrc   = Zero;
                end
            end
            MEM: begin
                ALUOp    = exe_aluop;
                ALUSrc   = 1'b1;
                MemRead  = is_ld;
                MemWrite = is_sd;
                PCWrite  = is_sd && dmem_ready;
            end
            WB: begin
                RegWrite = 1'b1;
                MemtoReg = is_ld;
                PCWrite  = 1'b1;
            end
            default: ;
        endcase
    end

    assign state         = state_q;
    assign illegal_instr = illegal_q;

    // State, IR and illegal-flag registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            ir_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            illegal_q <= illegal_d;
        end
    end

`ifdef SEQ_CTRL_PERF_COUNTERS_EN
    logic [31:0] cycle_q, cycle_d, instret_q, instret_d;

    // Busy-cycle and retired-instruction counters, wrapping naturally
    always_comb begin
        cycle_d   = cycle_q;
        instret_d = instret_q;
        if ((state_q != IDLE) && (state_q != HALT) && (state_q <= WB)) cycle_d = cycle_q + 32'd1;
        if (complete) instret_d = instret_q + 32'd1;
    end

    // Counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
        end
    end

    assign cycle_count   = cycle_q;
    assign instret_count = instret_q;
`else
    assign cycle_count   = '0;
    assign instret_count = '0;
`endif

endmodule

// File: tb/tb_seq_controller.sv
// tb_seq_controller: directed plus randomized checks of seq_controller against
// a per-instruction cycle-schedule reference model.
module tb_seq_controller;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0, stop = 1'b0;
    logic        imem_ready = 1'b0, dmem_ready = 1'b0, Zero = 1'b0;
    logic [31:0] instr = '0;
    logic        imem_req, ALUSrc, Branch, MemRead, MemWrite, MemtoReg, RegWrite;
    logic        IRWrite, PCWrite, PCSrc, illegal_instr;
    logic [3:0]  ALUOp;
    logic [2:0]  state;
    logic [31:0] cycle_count, instret_count;

    seq_controller dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .imem_req(imem_req), .imem_ready(imem_ready), .instr(instr),
        .dmem_ready(dmem_ready), .Zero(Zero), .ALUOp(ALUOp), .ALUSrc(ALUSrc),
        .Branch(Branch), .MemRead(MemRead), .MemWrite(MemWrite),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .PCSrc(PCSrc), .state(state),
        .illegal_instr(illegal_instr), .cycle_count(cycle_count),
        .instret_count(instret_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic       ireq, irw;
        logic [3:0] aop;
        logic       asrc, br, mrd, mwr, m2r, rw, pcw, pcs, ill;
    } ctl_t;

    typedef enum int {C_ADD, C_SUB, C_AND, C_OR, C_ADDI, C_LD, C_SD, C_BEQ, C_ILL} cls_t;

    int          vectors = 0;
    int          miscompares = 0;
    int unsigned m_cyc = 0, m_ret = 0;
    logic        m_ill = 1'b0;
    int          m_st = 0;   // where the DUT should be between instructions: 0 idle, 1 fetch, 6 halt

    function automatic bit rb();
        return ($urandom & 32'd1) != 32'd0;
    endfunction

    function automatic ctl_t base(input logic [2:0] st);
        ctl_t c;
        c     = '0;
        c.st  = st;
        c.ill = m_ill;
        return c;
    endfunction

    function automatic logic [3:0] alu_of(input cls_t c);
        case (c)
            C_ADD, C_ADDI: return 4'b0010;
            C_SUB, C_BEQ:  return 4'b0110;
            C_AND:         return 4'b0111;
            C_OR:          return 4'b0001;
            default:       return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] enc(input cls_t c);
        logic [4:0]  rd, rs1, rs2;
        logic [11:0] imm;
        logic [31:0] bad [7];
        rd  = 5'($urandom_range(0, 31));
        rs1 = 5'($urandom_range(0, 31));
        rs2 = 5'($urandom_range(0, 31));
        imm = 12'($urandom);
        bad[0] = 32'hFFFF_FFFF;
        bad[1] = 32'h0000_0000;
        bad[2] = {7'd0, rs2, rs1, 3'b001, rd, 7'b0110011};
        bad[3] = {imm, rs1, 3'b001, rd, 7'b0010011};
        bad[4] = {imm, rs1, 3'b010, rd, 7'b0000011};
        bad[5] = {imm[11:5], rs2, rs1, 3'b001, imm[4:0], 7'b1100011};
        bad[6] = {imm, rs1, 3'b000, rd, 7'b0110111};
        case (c)
            C_ADD:   return {7'h00, rs2, rs1, 3'b000, rd, 7'b0110011};
            C_SUB:   return {7'h20, rs2, rs1, 3'b000, rd, 7'b0110011};
            C_AND:   return {7'h00, rs2, rs1, 3'b111, rd, 7'b0110011};
            C_OR:    return {7'h00, rs2, rs1, 3'b110, rd, 7'b0110011};
            C_ADDI:  return {imm, rs1, 3'b000, rd, 7'b0010011};
            C_LD:    return {imm, rs1, 3'b011, rd, 7'b0000011};
            C_SD:    return {imm[11:5], rs2, rs1, 3'b011, imm[4:0], 7'b0100011};
            C_BEQ:   return {imm[11:5], rs2, rs1, 3'b000, imm[4:0], 7'b1100011};
            default: return bad[$urandom_range(0, 6)];
        endcase
    endfunction

    task automatic chk(input ctl_t e, input string tag);
        ctl_t        obs;
        logic [63:0] ecnt, ocnt;
        obs = {state, imem_req, IRWrite, ALUOp, ALUSrc, Branch, MemRead, MemWrite,
               MemtoReg, RegWrite, PCWrite, PCSrc, illegal_instr};
        vectors++;
        assert (obs === e) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, e);
        end
`ifdef SEQ_CTRL_PERF_COUNTERS_EN
        ecnt = {m_cyc, m_ret};
`else
        ecnt = '0;
`endif
        ocnt = {cycle_count, instret_count};
        vectors++;
        assert (ocnt === ecnt) else begin
            miscompares++;
            $error("FAIL %s_counters: observed %h expected %h", tag, ocnt, ecnt);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, check just after, then account the edge
    task automatic cyc(input logic i_start, i_ir, i_dr, i_z, i_stop, input logic [31:0] i_instr,
                       input ctl_t e, input bit done, input string tag);
        @(negedge clk);
        start = i_start; imem_ready = i_ir; dmem_ready = i_dr;
        Zero = i_z; stop = i_stop; instr = i_instr;
        #1;
        chk(e, tag);
        if (e.st >= 3'd1 && e.st <= 3'd5) m_cyc++;
        if (done) m_ret++;
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1; start = 1'b0; stop = 1'b0;
        imem_ready = 1'b0; dmem_ready = 1'b0; Zero = 1'b0;
        m_ill = 1'b0; m_cyc = 0; m_ret = 0; m_st = 0;
        #1;
        chk(base(3'd0), tag);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 2; i++)
            cyc(1'b0, rb(), rb(), rb(), rb(), $urandom, base(3'd0), 1'b0, "post_reset_idle");
    endtask

    task automatic do_instr(input logic [31:0] ins, input cls_t c, input int fw, input int mw,
                            input logic z, input logic stp, input bit abort_in_mem);
        ctl_t e;
        logic zin;
        if (m_st == 0) begin
            cyc(1'b1, rb(), rb(), rb(), rb(), $urandom, base(3'd0), 1'b0, "idle_start");
            m_st = 1;
        end
        for (int i = 0; i < fw; i++) begin
            e = base(3'd1); e.ireq = 1'b1;
            cyc(rb(), 1'b0, rb(), rb(), rb(), $urandom, e, 1'b0, "fetch_wait");
        end
        e = base(3'd1); e.ireq = 1'b1; e.irw = 1'b1;
        cyc(rb(), 1'b1, rb(), rb(), rb(), ins, e, 1'b0, "fetch");
        cyc(rb(), rb(), rb(), rb(), rb(), $urandom, base(3'd2), 1'b0, "decode");
        if (c == C_ILL) begin
            m_ill = 1'b1;
            m_st  = 6;
            for (int i = 0; i < 3; i++)
                cyc(1'b1, rb(), rb(), rb(), rb(), $urandom, base(3'd6), 1'b0, "halt");
            return;
        end
        zin = (c == C_BEQ) ? z : rb();
        e = base(3'd3);
        e.aop  = alu_of(c);
        e.asrc = (c == C_ADDI) || (c == C_LD) || (c == C_SD);
        if (c == C_BEQ) begin
            e.br = 1'b1; e.pcw = 1'b1; e.pcs = z;
        end
        cyc(rb(), rb(), rb(), zin, (c == C_BEQ) ? stp : rb(), $urandom, e, c == C_BEQ, "execute");
        if (c == C_BEQ) begin
            m_st = stp ? 0 : 1;
            return;
        end
        if (c == C_LD || c == C_SD) begin
            e = base(3'd4);
            e.asrc = 1'b1;
            e.mrd  = (c == C_LD);
            e.mwr  = (c == C_SD);
            for (int i = 0; i < mw; i++) begin
                cyc(rb(), rb(), 1'b0, rb(), rb(), $urandom, e, 1'b0, "mem_wait");
                if (abort_in_mem) begin
                    do_reset("reset_in_mem");
                    return;
                end
            end
            e.pcw = (c == C_SD);
            cyc(rb(), rb(), 1'b1, rb(), (c == C_SD) ? stp : rb(), $urandom, e, c == C_SD, "mem");
            if (c == C_SD) begin
                m_st = stp ? 0 : 1;
                return;
            end
        end
        e = base(3'd5);
        e.rw  = 1'b1;
        e.m2r = (c == C_LD);
        e.pcw = 1'b1;
        cyc(rb(), rb(), rb(), rb(), stp, $urandom, e, 1'b1, "wb");
        m_st = stp ? 0 : 1;
    endtask

    initial begin
        cls_t c;
        #2;
        do_reset("reset");
        do_instr(32'h0020_81B3, C_ADD, 0, 0, 1'b0, 1'b0, 1'b0);
        do_instr(32'h0080_B283, C_LD,  0, 3, 1'b0, 1'b0, 1'b0);
        do_instr(32'h0020_8463, C_BEQ, 0, 0, 1'b1, 1'b0, 1'b0);
        do_instr(32'h0020_8463, C_BEQ, 1, 0, 1'b0, 1'b0, 1'b0);
        do_instr(32'h4020_81B3, C_SUB, 2, 0, 1'b0, 1'b1, 1'b0);
        do_instr(enc(C_ADDI),   C_ADDI, 0, 0, 1'b0, 1'b0, 1'b0);
        do_instr(enc(C_SD),     C_SD,  0, 2, 1'b0, 1'b0, 1'b1);
        do_instr(32'hFFFF_FFFF, C_ILL, 0, 0, 1'b0, 1'b0, 1'b0);
        do_reset("reset_from_halt");
        for (int n = 0; n < 80; n++) begin
            c = ($urandom_range(0, 11) == 0) ? C_ILL : cls_t'($urandom_range(0, 7));
            do_instr(enc(c), c, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                     rb(), $urandom_range(0, 3) == 0, 1'b0);
            if (m_st == 6) do_reset("reset_after_illegal");
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

endmodule
